// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - streams a contiguous SRAM block over valid/ready with sop/eop
// A 2-entry skid FIFO hides the 1-cycle SRAM read latency so full throughput is one word per clock.
module sram_stream_reader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] address2,
   output logic              chipselect2,
   output logic              clken2,
   output logic              write2,
   output logic [3:0]        byteenable2,
   output logic [DATA_W-1:0] writedata2,
   input  logic [DATA_W-1:0] readdata2,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]    issue_left_q, issue_left_d;
   logic [CNT_W-1:0]    accept_left_q, accept_left_d;
   logic [CNT_W-1:0]    total_q, total_d;
   logic                done_q, done_d;
   logic                inflight_q;
   logic [DATA_W-1:0]   fifo_q [2];
   logic                wr_ptr_q, rd_ptr_q;
   logic [1:0]          fifo_count_q;

   logic                issue;
   logic                push;
   logic                pop;
   logic [2:0]          credit_used;

   assign push = inflight_q;
   assign pop  = out_valid & out_ready;

   // A word popped this cycle frees its slot in time for a read issued now.
   assign credit_used = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};

   always_comb begin
      state_d       = state_q;
      rd_addr_d     = rd_addr_q;
      issue_left_d  = issue_left_q;
      accept_left_d = accept_left_q;
      total_d       = total_q;
      done_d        = 1'b0;
      issue         = 1'b0;

      if (pop) begin
         accept_left_d = accept_left_q - ONE_C;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               rd_addr_d     = base_addr;
               issue_left_d  = word_count;
               accept_left_d = word_count;
               total_d       = word_count;
               if (word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (issue_left_q != '0 && credit_used < 3'd2) begin
               issue        = 1'b1;
               rd_addr_d    = rd_addr_q + ONE_A;
               issue_left_d = issue_left_q - ONE_C;
               if (issue_left_q == ONE_C) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (pop && accept_left_q == ONE_C) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         rd_addr_q     <= '0;
         issue_left_q  <= '0;
         accept_left_q <= '0;
         total_q       <= '0;
         done_q        <= 1'b0;
         inflight_q    <= 1'b0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         fifo_count_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         issue_left_q  <= issue_left_d;
         accept_left_q <= accept_left_d;
         total_q       <= total_d;
         done_q        <= done_d;
         inflight_q    <= issue;
         if (push) begin
            fifo_q[wr_ptr_q] <= readdata2;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         fifo_count_q <= fifo_count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign address2    = rd_addr_q;
   assign chipselect2 = issue;
   assign clken2      = issue;
   assign write2      = 1'b0;
   assign byteenable2 = 4'b1111;
   assign writedata2  = '0;
   assign out_valid   = (fifo_count_q != 2'd0);
   assign out_data    = fifo_q[rd_ptr_q];
   assign out_sop     = out_valid && (accept_left_q == total_q);
   assign out_eop     = out_valid && (accept_left_q == ONE_C);

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - randomized self-checking bench for sram_stream_reader
// Expected stream is built from the memory contents and base/count; timing from the block's latency rules.
module tb_sram_stream_reader;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 12;
   localparam int DEPTH  = 2048;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] address2;
   logic              chipselect2;
   logic              clken2;
   logic              write2;
   logic [3:0]        byteenable2;
   logic [DATA_W-1:0] writedata2;
   logic [DATA_W-1:0] readdata2 = '0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_sop;
   logic              out_eop;

   logic [DATA_W-1:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .address2   (address2),
      .chipselect2(chipselect2),
      .clken2     (clken2),
      .write2     (write2),
      .byteenable2(byteenable2),
      .writedata2 (writedata2),
      .readdata2  (readdata2),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sop    (out_sop),
      .out_eop    (out_eop)
   );

   // SRAM port 2: registered read, data valid the cycle after issue
   always @(posedge clk) begin
      if (chipselect2 && clken2) readdata2 <= mem[address2];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready
   task automatic do_xfer(input int base, input int n, input int mode, input bit restart);
      logic [DATA_W-1:0] exp_q[$];
      logic [DATA_W-1:0] prev_data;
      logic prev_sop, prev_eop, prev_stall, hs;
      int issued, accepted, dones, first_valid, done_at, budget;
      for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
      issued = 0; accepted = 0; dones = 0; first_valid = -1; done_at = -1;
      prev_stall = 1'b0; prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0;
      budget = n * 4 + 20;

      @(posedge clk); #1;
      start = 1'b1; base_addr = ADDR_W'(base); word_count = CNT_W'(n); out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (restart && c == 3) begin
            start = 1'b1; base_addr = ADDR_W'(base + 700); word_count = CNT_W'(n + 3);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         hs = out_valid && out_ready;
         if (n == 0 && c == 0) check("busy_zero", busy, 0);
         if (chipselect2) begin
            check("addr", address2, (base + issued) % DEPTH);
            check("credit_ok", (issued - accepted - (hs ? 1 : 0)) < 2, 1);
            check("clken", clken2, 1);
            issued++;
         end
         if (out_valid && first_valid < 0) first_valid = c;
         if (prev_stall && out_valid) begin
            check("stall_data", out_data, prev_data);
            check("stall_sop", out_sop, prev_sop);
            check("stall_eop", out_eop, prev_eop);
         end
         if (hs) begin
            if (accepted < n) begin
               check("data", out_data, exp_q[accepted]);
               check("sop", out_sop, accepted == 0);
               check("eop", out_eop, accepted == n - 1);
            end else begin
               check("extra_word", accepted, n);
            end
            accepted++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data = out_data; prev_sop = out_sop; prev_eop = out_eop;
         if (done) begin
            dones++;
            if (done_at < 0) done_at = c;
         end
         if (done_at >= 0 && c >= done_at + 3) break;
      end
      out_ready = 1'b0;
      check("words", accepted, n);
      check("issued", issued, n);
      check("done_cnt", dones, 1);
      check("busy_end", busy, 0);
      if (n == 0) check("done_at_zero", done_at, 0);
      if (mode == 0 && n > 0) begin
         check("first_valid", first_valid, 2);
         check("done_at", done_at, n + 2);
      end
   endtask

   initial begin
      int got;
      reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 + 32'(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_sop", out_sop, 0);
      check("rst_eop", out_eop, 0);
      check("rst_cs", chipselect2, 0);
      check("rst_clken", clken2, 0);
      check("rst_addr", address2, 0);
      check("rst_data", out_data, 0);
      check("write2", write2, 0);
      check("byteen", byteenable2, 4'hF);
      check("wdata", writedata2, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      do_xfer(32'h010, 4, 0, 1'b0);
      do_xfer(32'h7FE, 4, 0, 1'b0);
      do_xfer(32'h020, 8, 1, 1'b0);
      do_xfer(32'h300, 0, 0, 1'b0);
      do_xfer(32'h000, 2048, 0, 1'b0);
      do_xfer(32'h050, 6, 0, 1'b1);

      // reset in the middle of a 16-word transfer
      @(posedge clk); #1;
      start = 1'b1; base_addr = 11'h040; word_count = 12'd16; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         if (out_valid && out_ready) begin
            check("rst_pre_data", out_data, mem[(32'h040 + got) % DEPTH]);
            got++;
         end
      end
      check("rst_pre_hs", got, 5);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cs", chipselect2, 0);
      check("mid_rst_done", done, 0);
      do_xfer(32'h100, 2, 0, 1'b0);

      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int k = 0; k < 8; k++) begin
         do_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, 1'b0);
      end
      do_xfer(int'($urandom_range(0, DEPTH - 1)), 1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
